// File: rtl/regfile_wr_arb_if.sv
// regfile_wr_arb_if: request, clear and register-file write-port bundle for regfile_wr_arb.
// master: requesters / system side; slave: the arbiter.
interface regfile_wr_arb_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 256;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              clear_req;
  logic              clear_done;

  logic              W_En;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] WR;
  logic              grant_id;
  logic              busy;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clear_req,
    input  req0_ready, req1_ready, clear_done,
    input  W_En, W_Addr, WR, grant_id, busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clear_req,
    output req0_ready, req1_ready, clear_done,
    output W_En, W_Addr, WR, grant_id, busy
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: two-requester round-robin write arbiter for a 32x256 register file,
// with a 32-cycle bulk clear sequence.
// Optional feature: define RF_ARB_ZERO_PROTECT_EN to accept but suppress writes to
// address 0 from the requesters (the clear sequence still writes address 0).
// req0_ready/req1_ready are combinational; all other outputs are registered.
module regfile_wr_arb (
  input  logic             clk,
  input  logic             rst_n,
  regfile_wr_arb_if.slave  bus
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 256;
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(31);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              ptr;
  logic              ptr_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  logic              w_en_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [DATA_W-1:0] wr_q;
  logic              grant_q;
  logic              clear_done_q;
  logic              busy_q;

  logic              w_en_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] wr_nxt;
  logic              grant_nxt;
  logic              clear_done_nxt;
  logic              busy_nxt;

  logic              both_valid;
  logic              any_valid;
  logic              sel;
  logic              take;
  logic              ready0;
  logic              ready1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              zero_block;

  // Arbitration decode: lone requester wins, contention resolved by the pointer.
  always_comb begin
    both_valid = bus.req0_valid & bus.req1_valid;
    any_valid  = bus.req0_valid | bus.req1_valid;
    sel        = both_valid ? ptr : bus.req1_valid;
    take       = (state == ARB) && !bus.clear_req && any_valid;
    ready0     = take && !sel;
    ready1     = take && sel;
    sel_addr   = sel ? bus.req1_addr : bus.req0_addr;
    sel_data   = sel ? bus.req1_data : bus.req0_data;
  end

  // Address-0 write suppression; the handshake itself is unaffected.
`ifdef RF_ARB_ZERO_PROTECT_EN
  assign zero_block = (sel_addr == '0);
`else
  assign zero_block = 1'b0;
`endif

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: clear_req only matters in ARB; CLEAR runs to the last address.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB: begin
        if (bus.clear_req) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt == LAST_CNT) begin
          state_nxt = ARB;
        end
      end
    endcase
  end

  // Output / datapath next values; idle cycles hold address and data, drop W_En.
  always_comb begin
    ptr_nxt        = ptr;
    cnt_nxt        = cnt;
    w_en_nxt       = 1'b0;
    w_addr_nxt     = w_addr_q;
    wr_nxt         = wr_q;
    grant_nxt      = grant_q;
    clear_done_nxt = 1'b0;
    busy_nxt       = (state_nxt == CLEAR);
    case (state)
      ARB: begin
        if (bus.clear_req) begin
          cnt_nxt   = '0;
          grant_nxt = 1'b0;
        end else if (take) begin
          if (both_valid) begin
            ptr_nxt = ~sel;
          end
          if (!zero_block) begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = sel_addr;
            wr_nxt     = sel_data;
            grant_nxt  = sel;
          end
        end
      end
      CLEAR: begin
        w_en_nxt   = 1'b1;
        w_addr_nxt = cnt;
        wr_nxt     = '0;
        grant_nxt  = 1'b0;
        if (cnt == LAST_CNT) begin
          cnt_nxt        = '0;
          clear_done_nxt = 1'b1;
        end else begin
          cnt_nxt = ADDR_W'(cnt + ADDR_W'(1));
        end
      end
    endcase
  end

  // Registered outputs, pointer and clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= 1'b0;
      cnt          <= '0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      wr_q         <= '0;
      grant_q      <= 1'b0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ptr          <= ptr_nxt;
      cnt          <= cnt_nxt;
      w_en_q       <= w_en_nxt;
      w_addr_q     <= w_addr_nxt;
      wr_q         <= wr_nxt;
      grant_q      <= grant_nxt;
      clear_done_q <= clear_done_nxt;
      busy_q       <= busy_nxt;
    end
  end

  assign bus.W_En       = w_en_q;
  assign bus.W_Addr     = w_addr_q;
  assign bus.WR         = wr_q;
  assign bus.grant_id   = grant_q;
  assign bus.clear_done = clear_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: directed and randomized checks of regfile_wr_arb against a
// transaction-level model (pending clear writes kept as a queue of addresses).
module tb_regfile_wr_arb;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  regfile_wr_arb_if bus ();

  regfile_wr_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total   = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  int done_seen = 0;

  // Reference model state.
  logic         m_ptr;
  int           clr_q[$];
  logic         m_wen;
  logic [4:0]   m_waddr;
  logic [255:0] m_wr;
  logic         m_gid;
  logic         m_done;

  // Stimulus state: a held request per requester.
  logic         p0v, p1v;
  logic [4:0]   p0a, p1a;
  logic [255:0] p0d, p1d;
  logic         acc0, acc1;
  logic         cr;
  int           done_base;
  int           order [4] = '{0, 1, 0, 1};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr   = 1'b0;
    clr_q.delete();
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wr    = '0;
    m_gid   = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic drive_idle();
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
    bus.clear_req  = 1'b0;
  endtask

  // Called at a falling edge: assert reset, check asynchronous clearing, release.
  task automatic do_reset(input int hold);
    drive_idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_w_en",       256'(bus.W_En),       '0);
    check("rst_w_addr",     256'(bus.W_Addr),     '0);
    check("rst_wr",         bus.WR,               '0);
    check("rst_grant_id",   256'(bus.grant_id),   '0);
    check("rst_clear_done", 256'(bus.clear_done), '0);
    check("rst_busy",       256'(bus.busy),       '0);
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_w_en", 256'(bus.W_En), '0);
    check("rst_release_busy", 256'(bus.busy), '0);
  endtask

  // One clock cycle: drive, check handshake, advance model, check registered outputs.
  task automatic cycle(input logic v0, input logic [4:0] a0, input logic [255:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [255:0] d1,
                       input logic clr, output logic ac0, output logic ac1);
    int           win;
    logic         busy_now;
    logic [4:0]   wa;
    logic [255:0] wd;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    bus.clear_req  = clr;
    #1;
    busy_now = (clr_q.size() != 0);
    win = -1;
    if (!busy_now && !clr) begin
      if (v0 && v1)  win = m_ptr ? 1 : 0;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
    end
    ac0 = (win == 0);
    ac1 = (win == 1);
    check("busy_now",     256'(bus.busy),       256'(busy_now));
    check("req0_ready",   256'(bus.req0_ready), 256'(ac0));
    check("req1_ready",   256'(bus.req1_ready), 256'(ac1));
    check("ready_onehot", 256'(bus.req0_ready & bus.req1_ready), '0);

    m_done = 1'b0;
    if (busy_now) begin
      m_wen   = 1'b1;
      m_waddr = 5'(clr_q.pop_front());
      m_wr    = '0;
      m_gid   = 1'b0;
      m_done  = (clr_q.size() == 0);
    end else if (clr) begin
      for (int i = 0; i < 32; i++) clr_q.push_back(i);
      m_wen = 1'b0;
      m_gid = 1'b0;
    end else if (win >= 0) begin
      if (v0 && v1) m_ptr = (win == 0);
      wa = (win == 1) ? a1 : a0;
      wd = (win == 1) ? d1 : d0;
`ifdef RF_ARB_ZERO_PROTECT_EN
      if (wa == 5'd0) begin
        m_wen = 1'b0;
      end else begin
        m_wen = 1'b1; m_waddr = wa; m_wr = wd; m_gid = (win == 1);
      end
`else
      m_wen = 1'b1; m_waddr = wa; m_wr = wd; m_gid = (win == 1);
`endif
    end else begin
      m_wen = 1'b0;
    end

    @(posedge clk);
    #1;
    check("w_en",       256'(bus.W_En),       256'(m_wen));
    check("w_addr",     256'(bus.W_Addr),     256'(m_waddr));
    check("wr",         bus.WR,               m_wr);
    check("clear_done", 256'(bus.clear_done), 256'(m_done));
    check("busy",       256'(bus.busy),       256'(clr_q.size() != 0));
    if (m_wen || clr_q.size() != 0) check("grant_id", 256'(bus.grant_id), 256'(m_gid));
    if (bus.clear_done) done_seen++;
    @(negedge clk);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Single request right after reset release.
    cycle(1'b1, 5'd5, 256'hAA, 1'b0, 5'd0, '0, 1'b0, acc0, acc1);
    check("first_w_en",     256'(bus.W_En),     256'(1));
    check("first_w_addr",   256'(bus.W_Addr),   256'(5));
    check("first_wr",       bus.WR,             256'hAA);
    check("first_grant_id", 256'(bus.grant_id), '0);

    // Contention for four cycles: alternation starting with requester 0.
    p0a = 5'($urandom_range(1, 31)); p0d = rand256();
    p1a = 5'($urandom_range(1, 31)); p1d = rand256();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, p0a, p0d, 1'b1, p1a, p1d, 1'b0, acc0, acc1);
      check("rr_order", 256'(bus.grant_id), 256'(order[i]));
      if (acc0) begin p0a = 5'($urandom_range(1, 31)); p0d = rand256(); end
      if (acc1) begin p1a = 5'($urandom_range(1, 31)); p1d = rand256(); end
    end

    // Clear with both requesters waiting; a second clear_req mid-sequence is ignored.
    done_base = done_seen;
    cycle(1'b1, p0a, p0d, 1'b1, p1a, p1d, 1'b1, acc0, acc1);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, p0a, p0d, 1'b1, p1a, p1d, (i == 6), acc0, acc1);
    end
    check("clear_done_count", 256'(done_seen - done_base), 256'(1));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, p0a, p0d, 1'b1, p1a, p1d, 1'b0, acc0, acc1);
      if (acc0) begin p0a = 5'($urandom_range(0, 31)); p0d = rand256(); end
      if (acc1) begin p1a = 5'($urandom_range(0, 31)); p1d = rand256(); end
    end

    // Write to address 0 from requester 1.
    cycle(1'b0, 5'd3, '0, 1'b1, 5'd0, 256'h1234, 1'b0, acc0, acc1);
`ifdef RF_ARB_ZERO_PROTECT_EN
    check("addr0_w_en", 256'(bus.W_En), '0);
`else
    check("addr0_w_en",   256'(bus.W_En),   256'(1));
    check("addr0_w_addr", 256'(bus.W_Addr), '0);
`endif

    // Randomized traffic with held requests and occasional clears.
    p0v = 1'b0; p1v = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!p0v && $urandom_range(0, 2) != 0) begin
        p0v = 1'b1; p0a = 5'($urandom_range(0, 31)); p0d = rand256();
      end
      if (!p1v && $urandom_range(0, 2) != 0) begin
        p1v = 1'b1; p1a = 5'($urandom_range(0, 31)); p1d = rand256();
      end
      cr = ($urandom_range(0, 59) == 0);
      cycle(p0v, p0a, p0d, p1v, p1a, p1d, cr, acc0, acc1);
      if (acc0) p0v = 1'b0;
      if (acc1) p1v = 1'b0;
    end
    while (clr_q.size() != 0) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, acc0, acc1);

    // Reset in the middle of a clear (counter at 10): aborted, no clear_done.
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, acc0, acc1);
    while (clr_q.size() > 22) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, acc0, acc1);
    done_base = done_seen;
    do_reset(2);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, acc0, acc1);
    cycle(1'b1, 5'd9, 256'h55, 1'b0, '0, '0, 1'b0, acc0, acc1);
    check("post_abort_done", 256'(done_seen - done_base), '0);

    // Reset while a write is on the port discards it.
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 256'h77, 1'b0, acc0, acc1);
    do_reset(2);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, acc0, acc1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL have ports req0_valid input 1, req0_addr input 5, req0_data input 256: requester 0 write request.
REQ-003 SHALL have port req0_ready output 1: requester 0 accepted this cycle.
REQ-004 SHALL have ports req1_valid input 1, req1_addr input 5, req1_data input 256, req1_ready output 1: requester 1, same meaning as requester 0.
REQ-005 SHALL have ports clear_req input 1 (pulse: zero all 32 registers) and clear_done output 1 (one-cycle pulse when the clear completes).
REQ-006 SHALL have ports W_En output 1, W_Addr output 5, WR output 256: registered drive of the 32x256 register file write port.
REQ-007 SHALL have ports grant_id output 1 (source of the current W_En write) and busy output 1 (high in CLEAR).

Function
REQ-008 SHALL implement two states, ARB and CLEAR, and SHALL enter ARB on reset.
REQ-009 In ARB, a requester's ready SHALL be combinational and high only when it is selected; a transfer occurs when valid and ready are both high.
REQ-010 Only one of req0_ready and req1_ready SHALL be high in any cycle.
REQ-011 If exactly one requester is valid, it SHALL be selected regardless of priority.
REQ-012 If both requesters are valid, the requester indicated by a 1-bit priority pointer SHALL be selected.
REQ-013 After a transfer with both requesters valid, the pointer SHALL move to the loser; otherwise the pointer SHALL be unchanged.
REQ-014 An accepted request SHALL appear on W_En/W_Addr/WR/grant_id on the cycle after acceptance, for exactly one cycle (latency 1).
REQ-015 With no transfer in a cycle, W_En SHALL be 0 in the next cycle, and W_Addr and WR SHALL hold their values.
REQ-016 A valid requester that is not selected SHALL keep its request stable until accepted; the block SHALL NOT drop or reorder a held request.
REQ-017 clear_req sampled high in ARB SHALL move the FSM to CLEAR on the next edge.
REQ-018 clear_req SHALL take precedence over both requesters: both ready outputs SHALL be 0 in the cycle clear_req is high.
REQ-019 A write already registered on W_En when clear_req arrives SHALL still complete.
REQ-020 In CLEAR, a 5-bit counter SHALL issue W_En=1, W_Addr=0..31 ascending, WR=0 on 32 consecutive cycles; both ready outputs SHALL be 0 and busy SHALL be 1.
REQ-021 After the W_Addr=31 write, the FSM SHALL return to ARB, pulse clear_done for one cycle, and wrap the counter to 0.
REQ-022 clear_req asserted during CLEAR SHALL be ignored and SHALL NOT restart the counter.
REQ-023 In CLEAR, grant_id SHALL be 0.
REQ-024 The priority pointer SHALL be unchanged by a clear.

Reset
REQ-025 On rst_n low, the following SHALL be forced asynchronously: W_En=0, W_Addr=0, WR=0, grant_id=0, clear_done=0, busy=0, priority pointer=0 (requester 0 first), clear counter=0, state=ARB.
REQ-026 Reset asserted mid-CLEAR SHALL abort the clear with no clear_done pulse.
REQ-027 Reset asserted with a write pending SHALL discard that write.
REQ-028 Outputs SHALL leave their reset values only on the first rising clk edge after rst_n deasserts.

Configuration
REQ-029 Macro RF_ARB_ZERO_PROTECT_EN, when defined, SHALL accept requests to address 0 normally (ready asserted, pointer updated) but keep W_En=0 for that write; CLEAR still writes address 0.
REQ-030 Without RF_ARB_ZERO_PROTECT_EN, address 0 SHALL be written like any other address.

Verification
REQ-031 Reset release, req0 valid addr=5 data=0xAA -> req0_ready=1 the same cycle; next cycle W_En=1, W_Addr=5, WR=0xAA, grant_id=0.
REQ-032 Both valid for 4 cycles, pointer=0 -> grants in order 0,1,0,1; no cycle with both ready high.
REQ-033 clear_req pulse with both requesters valid -> ready outputs 0 for 33 cycles, W_Addr 0..31 with WR=0, clear_done pulse after addr 31, then arbitration resumes with the pointer unchanged.
REQ-034 rst_n low at clear count 10 -> W_En=0 immediately, no clear_done; after release, state ARB.
REQ-035 RF_ARB_ZERO_PROTECT_EN defined, req1 addr=0 -> req1_ready=1, W_En stays 0 next cycle; without the macro, W_En=1 with W_Addr=0.
